run_controller: RTL and testbench
=================================

RUN_CONTROLLER -- requirements
Module: run_controller

Interface
REQ-001 SHALL have port: clock  input  1  single system clock; all state changes on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: run_req  input  1  one-cycle pulse, start free-running execution.
REQ-004 SHALL have port: step_req  input  1  one-cycle pulse, advance pipeline exactly one cycle.
REQ-005 SHALL have port: halt_req  input  1  one-cycle pulse, stop execution.
REQ-006 SHALL have port: rate_div  input  8  run-mode divider; one pipeline advance every rate_div+1 clocks.
REQ-007 SHALL have port: pc  input  16  current program counter from fetch stage.
REQ-008 SHALL have port: bp_addr  input  16  breakpoint address.
REQ-009 SHALL have port: bp_en  input  1  breakpoint enable (level).
REQ-010 SHALL have port: pipe_en  output  1  registered one-cycle pipeline clock-enable pulse.
REQ-011 SHALL have port: state  output  2  FSM state: HALT=0, STEP=1, RUN=2, BREAK=3.
REQ-012 SHALL have port: pulse_cnt  output  16  count of pipe_en pulses issued.
REQ-013 SHALL have port: bp_hit  output  1  sticky, breakpoint caused the stop.

Function
REQ-014 SHALL implement states HALT, STEP, RUN, BREAK; HALT and BREAK issue no pulses.
REQ-015 Request priority SHALL be reset > halt_req > run_req > step_req when sampled on the same edge.
REQ-016 HALT/BREAK + step_req SHALL go to STEP; STEP SHALL last exactly one clock with pipe_en=1, then return to HALT.
REQ-017 Steps SHALL ignore breakpoints.
REQ-018 HALT/BREAK + run_req SHALL go to RUN, clear div counter to 0, set skip_bp, clear bp_hit.
REQ-019 In RUN, div counter SHALL increment each clock; when counter == rate_div, pipe_en SHALL assert the next clock and counter SHALL return to 0.
REQ-020 First RUN pulse SHALL appear rate_div+2 clocks after the edge sampling run_req; subsequent pulses every rate_div+1 clocks; rate_div=0 gives continuous pipe_en.
REQ-021 rate_div changes during RUN SHALL take effect at the next compare; if counter > new rate_div, counter SHALL wrap through 255 to 0.
REQ-022 At a would-be-pulse edge in RUN, if bp_en=1, pc==bp_addr and skip_bp=0, SHALL go to BREAK, suppress that pulse, set bp_hit.
REQ-023 skip_bp SHALL clear on the first pulse issued after RUN entry, so resuming at the breakpoint address proceeds.
REQ-024 halt_req in RUN or STEP SHALL go to HALT with no further pulse; a pulse already registered SHALL complete.
REQ-025 run_req in RUN and step_req in RUN/STEP SHALL be ignored.
REQ-026 pulse_cnt SHALL increment once per pipe_en clock, wrapping 0xFFFF to 0x0000.
REQ-027 pipe_en SHALL never be high for two consecutive clocks unless in RUN with rate_div=0.

Reset
REQ-028 reset SHALL force state=HALT, pipe_en=0, pulse_cnt=0, bp_hit=0, div counter=0, skip_bp=0 on the next edge, overriding all requests.
REQ-029 reset mid-RUN or mid-STEP SHALL suppress any pending pulse; pipe_en SHALL be 0 the clock after reset sampled.

Configuration
REQ-030 Macro RUN_CONTROLLER_BUDGET_EN defined SHALL add input budget (16) and output budget_hit (1, sticky, reset 0).
REQ-031 With it: budget≠0 SHALL halt RUN to HALT immediately after the budget-th pulse since RUN entry, setting budget_hit; budget=0 means unlimited; run_req clears budget_hit and the per-run count.
REQ-032 Without it: ports absent, RUN continues until halt_req, breakpoint or reset.

Verification
REQ-033 Reset, then step_req x3 spaced 4 clocks -> exactly 3 single-clock pipe_en pulses, pulse_cnt=3, state returns to 0.
REQ-034 run_req with rate_div=3 -> first pulse 5 clocks after run_req, then every 4 clocks; halt_req -> no further pulses, state=0.
REQ-035 bp_en=1, bp_addr=0x0010, pc advancing by 4 per pulse from 0 -> BREAK with pc=0x0010, bp_hit=1; run_req -> next pulse issued, pc passes 0x0010.
REQ-036 run_req, halt_req and step_req on same edge in HALT -> state stays 0, no pulse; run_req+step_req -> RUN.
REQ-037 Reset asserted mid-RUN with rate_div=0 -> pipe_en=0 next clock, pulse_cnt=0, state=0.
REQ-038 With RUN_CONTROLLER_BUDGET_EN, budget=5, rate_div=0 -> exactly 5 pulses, state=0, budget_hit=1.

Source files
------------

// File: rtl/run_controller.sv
// Run/step/halt sequencer producing a registered pipeline clock-enable with breakpoint stop.
// Defining RUN_CONTROLLER_BUDGET_EN adds a per-run pulse budget (budget / budget_hit ports).
module run_controller (
  input  logic        clock,
  input  logic        reset,
  input  logic        run_req,
  input  logic        step_req,
  input  logic        halt_req,
  input  logic [7:0]  rate_div,
  input  logic [15:0] pc,
  input  logic [15:0] bp_addr,
  input  logic        bp_en,
`ifdef RUN_CONTROLLER_BUDGET_EN
  input  logic [15:0] budget,
  output logic        budget_hit,
`endif
  output logic        pipe_en,
  output logic [1:0]  state,
  output logic [15:0] pulse_cnt,
  output logic        bp_hit
);

  typedef enum logic [1:0] {
    ST_HALT  = 2'd0,
    ST_STEP  = 2'd1,
    ST_RUN   = 2'd2,
    ST_BREAK = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic        skip_q, skip_d;
  logic        bp_hit_q, bp_hit_d;
  logic        pipe_en_q, pipe_en_d;
  logic [15:0] pulse_cnt_q, pulse_cnt_d;
  logic        bp_match;

`ifdef RUN_CONTROLLER_BUDGET_EN
  logic [15:0] run_cnt_q, run_cnt_d;
  logic        budget_hit_q, budget_hit_d;
`endif

  // skip_bp lets a run resumed at the breakpoint address issue its first pulse
  assign bp_match = bp_en && (pc == bp_addr) && !skip_q;

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    skip_d      = skip_q;
    bp_hit_d    = bp_hit_q;
    pipe_en_d   = 1'b0;
    pulse_cnt_d = pulse_cnt_q;
`ifdef RUN_CONTROLLER_BUDGET_EN
    run_cnt_d    = run_cnt_q;
    budget_hit_d = budget_hit_q;
`endif

    case (state_q)
      ST_HALT, ST_BREAK: begin
        if (halt_req) begin
          state_d = ST_HALT;
        end else if (run_req) begin
          state_d  = ST_RUN;
          div_d    = 8'd0;
          skip_d   = 1'b1;
          bp_hit_d = 1'b0;
`ifdef RUN_CONTROLLER_BUDGET_EN
          run_cnt_d    = 16'd0;
          budget_hit_d = 1'b0;
`endif
        end else if (step_req) begin
          state_d   = ST_STEP;
          pipe_en_d = 1'b1;
        end
      end

      ST_STEP: begin
        state_d = ST_HALT;
      end

      ST_RUN: begin
        if (halt_req) begin
          state_d = ST_HALT;
        end else if (div_q == rate_div) begin
          div_d = 8'd0;
          if (bp_match) begin
            state_d  = ST_BREAK;
            bp_hit_d = 1'b1;
          end else begin
            pipe_en_d = 1'b1;
            skip_d    = 1'b0;
`ifdef RUN_CONTROLLER_BUDGET_EN
            run_cnt_d = run_cnt_q + 16'd1;
            if ((budget != 16'd0) && (run_cnt_d == budget)) begin
              state_d      = ST_HALT;
              budget_hit_d = 1'b1;
            end
`endif
          end
        end else begin
          // a counter above a freshly lowered rate_div wraps through 255
          div_d = div_q + 8'd1;
        end
      end

      default: begin
        state_d = ST_HALT;
      end
    endcase

    if (pipe_en_d) begin
      pulse_cnt_d = pulse_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_HALT;
      div_q       <= 8'd0;
      skip_q      <= 1'b0;
      bp_hit_q    <= 1'b0;
      pipe_en_q   <= 1'b0;
      pulse_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      skip_q      <= skip_d;
      bp_hit_q    <= bp_hit_d;
      pipe_en_q   <= pipe_en_d;
      pulse_cnt_q <= pulse_cnt_d;
    end
  end

`ifdef RUN_CONTROLLER_BUDGET_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      run_cnt_q    <= 16'd0;
      budget_hit_q <= 1'b0;
    end else begin
      run_cnt_q    <= run_cnt_d;
      budget_hit_q <= budget_hit_d;
    end
  end

  assign budget_hit = budget_hit_q;
`endif

  assign pipe_en   = pipe_en_q;
  assign state     = state_q;
  assign pulse_cnt = pulse_cnt_q;
  assign bp_hit    = bp_hit_q;

endmodule

// File: tb/tb_run_controller.sv
// Bench for run_controller: timing model of pulse schedule plus directed literal checks.
module tb_run_controller;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        run_req = 1'b0, step_req = 1'b0, halt_req = 1'b0, bp_en = 1'b0;
  logic [7:0]  rate_div = 8'd0;
  logic [15:0] pc = 16'd0, bp_addr = 16'd0, budget = 16'd0;
  logic        pipe_en, bp_hit;
  logic [1:0]  state;
  logic [15:0] pulse_cnt;
`ifdef RUN_CONTROLLER_BUDGET_EN
  logic        budget_hit;
`endif

  int vec = 0, errs = 0, obs = 0;
  bit check_en = 1'b0;

  run_controller dut (
    .clock(clock), .reset(reset), .run_req(run_req), .step_req(step_req),
    .halt_req(halt_req), .rate_div(rate_div), .pc(pc), .bp_addr(bp_addr), .bp_en(bp_en),
`ifdef RUN_CONTROLLER_BUDGET_EN
    .budget(budget), .budget_hit(budget_hit),
`endif
    .pipe_en(pipe_en), .state(state), .pulse_cnt(pulse_cnt), .bp_hit(bp_hit)
  );

  always #5 clock = ~clock;

  // Model: in RUN a pulse is due on edge t when (t - mark - 1) mod 256 equals rate_div,
  // mark being the edge of run entry or of the previous due point.
  int cyc = 0, mark = 0, m_state = 0, m_cnt = 0, m_rc = 0;
  bit m_pipe = 1'b0, m_skip = 1'b0, m_bp = 1'b0, m_bh = 1'b0;

  always @(posedge clock) begin
    cyc++;
    m_pipe = 1'b0;
    if (reset) begin
      m_state = 0; m_bp = 0; m_cnt = 0; m_skip = 0; m_bh = 0; m_rc = 0;
    end else begin
      case (m_state)
        0, 3: begin
          if (halt_req) m_state = 0;
          else if (run_req) begin
            m_state = 2; mark = cyc; m_skip = 1; m_bp = 0; m_rc = 0; m_bh = 0;
          end else if (step_req) begin
            m_state = 1; m_pipe = 1;
          end
        end
        1: m_state = 0;
        default: begin
          if (halt_req) m_state = 0;
          else if (((cyc - mark - 1) % 256) == int'(rate_div)) begin
            mark = cyc;
            if (bp_en && pc == bp_addr && !m_skip) begin
              m_state = 3; m_bp = 1;
            end else begin
              m_pipe = 1; m_skip = 0; m_rc++;
              if (budget != 16'd0 && m_rc == int'(budget)) begin
                m_state = 0; m_bh = 1;
              end
            end
          end
        end
      endcase
    end
    if (m_pipe) m_cnt = (m_cnt + 1) % 65536;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  always @(negedge clock) begin
    if (check_en) begin
      check("state", 32'(state), 32'(m_state));
      check("pipe_en", 32'(pipe_en), 32'(m_pipe));
      check("pulse_cnt", 32'(pulse_cnt), 32'(m_cnt));
      check("bp_hit", 32'(bp_hit), 32'(m_bp));
`ifdef RUN_CONTROLLER_BUDGET_EN
      check("budget_hit", 32'(budget_hit), 32'(m_bh));
`endif
    end
  end

  // The fetch stage advances pc by 4 for every issued pulse.
  task automatic tick();
    @(negedge clock);
    if (pipe_en === 1'b1) obs++;
    if (m_pipe) pc = pc + 16'd4;
  endtask

  task automatic wait_pulse(input int max, output int n);
    n = 0;
    do begin tick(); n++; end while (pipe_en !== 1'b1 && n <= max);
  endtask

  task automatic wait_state(input logic [1:0] want, input int max, output int n);
    n = 0;
    do begin tick(); n++; end while (state !== want && n <= max);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, base;
    reset = 1'b1;
    tick(); tick();
    check_en = 1'b1;
    check("rst_state", 32'(state), 32'd0);
    check("rst_pipe_en", 32'(pipe_en), 32'd0);
    check("rst_pulse_cnt", 32'(pulse_cnt), 32'd0);
    check("rst_bp_hit", 32'(bp_hit), 32'd0);
    reset = 1'b0;
    tick();

    // three single steps, 4 clocks apart
    base = obs;
    for (int i = 0; i < 3; i++) begin
      step_req = 1'b1; tick(); step_req = 1'b0;
      repeat (3) tick();
    end
    check("step_pulses", 32'(obs - base), 32'd3);
    check("step_cnt", 32'(pulse_cnt), 32'd3);
    check("step_state", 32'(state), 32'd0);

    // run at rate_div=3: pulse visible after edge 4, sampled by consumers at clock 5
    rate_div = 8'd3;
    run_req = 1'b1; tick(); run_req = 1'b0;
    wait_pulse(20, n); check("run_first", 32'(n), 32'd4);
    wait_pulse(20, n); check("run_gap", 32'(n), 32'd4);
    halt_req = 1'b1; tick(); halt_req = 1'b0;
    base = obs;
    repeat (20) tick();
    check("halt_quiet", 32'(obs - base), 32'd0);
    check("halt_state", 32'(state), 32'd0);

    // request priority on a single edge
    base = obs;
    run_req = 1'b1; halt_req = 1'b1; step_req = 1'b1; tick();
    run_req = 1'b0; halt_req = 1'b0; step_req = 1'b0; tick();
    check("prio_state", 32'(state), 32'd0);
    check("prio_pulse", 32'(obs - base), 32'd0);
    run_req = 1'b1; step_req = 1'b1; tick();
    run_req = 1'b0; step_req = 1'b0;
    check("run_over_step", 32'(state), 32'd2);
    halt_req = 1'b1; tick(); halt_req = 1'b0; tick();

    // breakpoint at 0x0010, pc stepping by 4 from 0
    pc = 16'h0000; bp_addr = 16'h0010; bp_en = 1'b1; rate_div = 8'd1;
    base = obs;
    run_req = 1'b1; tick(); run_req = 1'b0;
    wait_state(2'd3, 60, n);
    check("bp_time", 32'(n), 32'd10);
    check("bp_state", 32'(state), 32'd3);
    check("bp_pc", 32'(pc), 32'h10);
    check("bp_flag", 32'(bp_hit), 32'd1);
    check("bp_pulses", 32'(obs - base), 32'd4);
    run_req = 1'b1; tick(); run_req = 1'b0;
    wait_pulse(10, n); check("resume_pulse", 32'(n), 32'd2);
    check("resume_pc", 32'(pc), 32'h14);
    check("resume_bp_clr", 32'(bp_hit), 32'd0);
    repeat (6) tick();
    check("resume_running", 32'(state), 32'd2);
    halt_req = 1'b1; tick(); halt_req = 1'b0; bp_en = 1'b0; tick();

    // lowering rate_div below the live counter wraps it through 255
    rate_div = 8'd10;
    run_req = 1'b1; tick(); run_req = 1'b0;
    repeat (5) tick();
    rate_div = 8'd2;
    wait_pulse(300, n); check("wrap_gap", 32'(n), 32'd254);
    wait_pulse(20, n);  check("wrap_next", 32'(n), 32'd3);
    halt_req = 1'b1; tick(); halt_req = 1'b0; tick();

`ifdef RUN_CONTROLLER_BUDGET_EN
    budget = 16'd5; rate_div = 8'd0;
    base = obs;
    run_req = 1'b1; tick(); run_req = 1'b0;
    repeat (20) tick();
    check("budget_pulses", 32'(obs - base), 32'd5);
    check("budget_state", 32'(state), 32'd0);
    check("budget_flag", 32'(budget_hit), 32'd1);
    budget = 16'd0;
    run_req = 1'b1; tick(); run_req = 1'b0;
    check("budget_clr", 32'(budget_hit), 32'd0);
    halt_req = 1'b1; tick(); halt_req = 1'b0; tick();
`endif

    // reset in the middle of continuous run
    rate_div = 8'd0;
    run_req = 1'b1; tick(); run_req = 1'b0;
    repeat (6) tick();
    check("cont_pipe_en", 32'(pipe_en), 32'd1);
    reset = 1'b1; tick();
    check("mid_rst_pipe_en", 32'(pipe_en), 32'd0);
    check("mid_rst_cnt", 32'(pulse_cnt), 32'd0);
    check("mid_rst_state", 32'(state), 32'd0);
    reset = 1'b0;
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
